spi_slave_byte: RTL and testbench

Byte-oriented SPI responder, the peripheral-side counterpart of the team's SPI master. It is used for loop-back verification of the master and as a target for FPGA-to-FPGA links. It oversamples CS/SCK/MOSI on the system clock and supports all four CPOL/CPHA modes, MSB first. It delivers each received byte on a one-cycle strobe and shifts out bytes from a one-deep transmit holding register with a valid/ready load handshake.

---
 rtl/spi_slave_byte.sv | 249 ++++++++++++++++++++++++
 tb/tb_spi_slave_byte.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_byte.sv
// ---------------------------------------------------------------------------
// spi_slave_byte
//
// Byte-oriented SPI responder (peripheral side), MSB first, all four
// CPOL/CPHA modes. CS, SCK and MOSI are oversampled on clk through 2-flop
// synchronizers. A third register on CS and SCK provides edge detection.
// Each received byte is delivered on a one-cycle rx_valid strobe. Outgoing
// bytes come from a one-deep holding register that is loaded through a
// tx_valid/tx_ready handshake. When the holding register is empty at a
// byte boundary, DEFAULT_TX is shifted out instead.
//
// Optional feature macro: SPI_SLAVE_STATUS_EN
//   Defined:   adds the sticky tx_underrun / frame_abort flags and the
//              status_clr input.
//   Undefined: those ports are absent. An underrun still sends DEFAULT_TX.
//
// Timing with a pin edge at cycle 0:
//   - Synchronized level is visible after clk edge 2.
//   - The edge pulse is high during cycle 3.
//   - The action registers at clk edge 3, so miso or rx_valid is seen in
//     cycle 4.
// ---------------------------------------------------------------------------
module spi_slave_byte #(
  parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       cs_n,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
`ifdef SPI_SLAVE_STATUS_EN
  ,
  output logic       tx_underrun,
  output logic       frame_abort,
  input  logic       status_clr
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } state_t;

  state_t state, state_nxt;

  // Synchronizer pipes:
  //   [0] and [1] form the 2-flop synchronizer.
  //   [2] is the delayed copy used for edge detection.
  logic [2:0] cs_pipe;
  logic [2:0] sck_pipe;
  logic [1:0] mosi_pipe;

  logic       cs_fall, cs_rise;
  logic       sck_rise, sck_fall;
  logic       sample_edge, shift_edge;
  logic       mosi_s;

  logic [1:0] mode_q;            // {CPOL, CPHA} frozen for the frame
  logic [2:0] bit_cnt;           // samples taken in the current byte
  logic       byte_done;         // 8th sample seen, reload not yet done
  logic [6:0] rx_shift;          // first seven bits of the byte being received
  logic [7:0] shifter;           // shifter[7] is the bit currently on miso
  logic [7:0] hold_data;
  logic       hold_full;
  logic       hold_full_nxt;

  logic       reload;            // shifter takes the next byte this cycle
  logic       shift_bit;         // drive the next bit of the current byte
  logic       sample;            // capture mosi this cycle
  logic       tx_load;           // handshake completes this cycle
  logic       take;              // reload consumes the holding register
  logic [7:0] reload_byte;

  // Shift the asynchronous pins through the synchronizer and edge registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_pipe   <= 3'b111;
      sck_pipe  <= 3'b000;
      mosi_pipe <= 2'b00;
    end else begin
      cs_pipe   <= {cs_pipe[1:0], cs_n};
      sck_pipe  <= {sck_pipe[1:0], sck};
      mosi_pipe <= {mosi_pipe[0], mosi};
    end
  end

  assign cs_fall  = !cs_pipe[1] &&  cs_pipe[2];
  assign cs_rise  =  cs_pipe[1] && !cs_pipe[2];
  assign sck_rise =  sck_pipe[1] && !sck_pipe[2];
  assign sck_fall = !sck_pipe[1] &&  sck_pipe[2];
  assign mosi_s   = mosi_pipe[1];

  // Sample on the rising edge when CPOL == CPHA, else on the falling edge.
  // The shift edge is always the opposite edge.
  assign sample_edge = (mode_q[1] == mode_q[0]) ? sck_rise : sck_fall;
  assign shift_edge  = (mode_q[1] == mode_q[0]) ? sck_fall : sck_rise;

  // busy follows the synchronized chip select. It falls back together
  // with the return to IDLE.
  assign busy = !cs_pipe[2];

  // Advance the frame state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Decide the next state and the per-cycle datapath strobes.
  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_nxt = state;
    reload    = 1'b0;
    shift_bit = 1'b0;
    sample    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cs_fall) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        reload    = 1'b1;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        sample = sample_edge;
        if (shift_edge) begin
          if (byte_done) begin
            // Byte boundary: the next byte goes out from its bit 7.
            reload = 1'b1;
          end else if (!(mode_q[0] && bit_cnt == 3'd0)) begin
            // With CPHA=1, the first shift edge of a byte re-drives bit 7,
            // which is already on miso.
            shift_bit = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Deselect ends the frame from any state and drops the partial byte.
    if (cs_rise) begin
      state_nxt = ST_IDLE;
      reload    = 1'b0;
      shift_bit = 1'b0;
      sample    = 1'b0;
    end
  end

  // Holding register bookkeeping.
  // A load is only accepted when the register is empty, so a load and a
  // take never overlap. A same-cycle load therefore lands after the reload
  // has already taken DEFAULT_TX.
  assign tx_load     = tx_valid && tx_ready;
  assign take        = reload && hold_full;
  assign reload_byte = hold_full ? hold_data : DEFAULT_TX;

  always_comb begin
    hold_full_nxt = hold_full;
    if (tx_load)   hold_full_nxt = 1'b1;
    else if (take) hold_full_nxt = 1'b0;
  end

  // Track holding-register occupancy and publish tx_ready as a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      tx_ready  <= 1'b1;
    end else begin
      hold_full <= hold_full_nxt;
      tx_ready  <= !hold_full_nxt;
    end
  end

  // Data-only registers: capture the loaded byte and run the transmit
  // shifter.
  // NOTE: these registers carry no reset. The hold_full flag and the FSM
  // decide when their contents are used, so resetting them would only add
  // reset fan-out.
  always_ff @(posedge clk) begin
    if (tx_load) hold_data <= tx_data;
    if (reload)         shifter <= reload_byte;
    else if (shift_bit) shifter <= {shifter[6:0], 1'b0};
  end

  // Receive path, bit counter, miso drive and the per-frame mode latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= 2'b00;
      bit_cnt   <= 3'd0;
      byte_done <= 1'b0;
      rx_shift  <= 7'd0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      miso      <= 1'b1;
      miso_oe   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == ST_IDLE && cs_fall) mode_q <= mode;
      if (state_nxt == ST_IDLE) begin
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
        miso      <= 1'b1;
        miso_oe   <= 1'b0;
      end else begin
        if (sample) begin
          rx_shift <= {rx_shift[5:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;  // wraps 7 -> 0 at the byte boundary
          if (bit_cnt == 3'd7) begin
            rx_data   <= {rx_shift, mosi_s};
            rx_valid  <= 1'b1;
            byte_done <= 1'b1;
          end
        end
        if (reload) begin
          miso      <= reload_byte[7];
          miso_oe   <= 1'b1;
          byte_done <= 1'b0;
        end else if (shift_bit) begin
          miso <= shifter[6];
        end
      end
    end
  end

`ifdef SPI_SLAVE_STATUS_EN
  // Sticky status flags. A clear wins over a set in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || status_clr) begin
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      if (reload && !hold_full) tx_underrun <= 1'b1;
      if (cs_rise && state == ST_SHIFT && bit_cnt != 3'd0) frame_abort <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_byte.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_byte
//
// Bench-side SPI master driving spi_slave_byte at SCK = clk/10.
// Expected received bytes are queued when the master drives them and are
// popped on rx_valid. Expected miso bytes are queued when the transmit side
// is set up and are popped as the master completes each byte.
// ---------------------------------------------------------------------------
module tb_spi_slave_byte;

  localparam int HALF = 5;  // SCK half-period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       cs_n, sck, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy;
`ifdef SPI_SLAVE_STATUS_EN
  logic       tx_underrun, frame_abort, status_clr;
`endif

  always #5 clk = ~clk;

  spi_slave_byte #(.DEFAULT_TX(8'hFF)) dut (
    .clk(clk), .rst(rst), .mode(mode), .cs_n(cs_n), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_STATUS_EN
    , .tx_underrun(tx_underrun), .frame_abort(frame_abort), .status_clr(status_clr)
`endif
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         rx_cnt   = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] miso_exp[$];
  logic [7:0] mosi_buf[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance n clock edges and land 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_push(input logic [7:0] b);
    int t = 0;
    while (!tx_ready && t < 400) begin
      tick(1);
      t++;
    end
    check("tx_ready_wait", tx_ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  function automatic logic bit_at(input int i, input int nbits);
    logic [7:0] b;
    if (i >= nbits) return 1'b0;
    b = mosi_buf[i / 8];
    return b[7 - (i % 8)];
  endfunction

  task automatic status_clear();
`ifdef SPI_SLAVE_STATUS_EN
    status_clr = 1'b1;
    tick(1);
    status_clr = 1'b0;
    check("clr_underrun", tx_underrun, 1'b0);
    check("clr_abort", frame_abort, 1'b0);
`endif
  endtask

  // One CS-low frame of nbits.
  // Full bytes are queued to the receive scoreboard, and received miso
  // bytes are checked against miso_exp. hook_bit >= 0 pulses tx_valid
  // (byte C3) exactly in the reload cycle that follows that bit's trailing
  // edge.
  task automatic spi_xfer(input logic [1:0] m, input int nbits, input int hook_bit);
    logic       cpol, cpha;
    logic [7:0] got;
    cpol = m[1];
    cpha = m[0];
    got  = 8'h00;
    mode = m;
    sck  = cpol;
    mosi = cpha ? 1'b0 : bit_at(0, nbits);
    tick(4);
    cs_n = 1'b0;
    tick(6);
    for (int i = 0; i < nbits; i++) begin
      if (i % 8 == 0 && i + 8 <= nbits) rx_exp.push_back(mosi_buf[i / 8]);
      if (!cpha) begin
        got = {got[6:0], miso};
        sck = ~cpol;
        tick(HALF);
        sck  = cpol;
        mosi = bit_at(i + 1, nbits);
        if (i == hook_bit) begin
          tick(2);
          check("hook_ready", tx_ready, 1'b1);
          tx_data  = 8'hC3;
          tx_valid = 1'b1;
          tick(1);
          tx_valid = 1'b0;
          tick(HALF - 3);
        end else begin
          tick(HALF);
        end
      end else begin
        sck  = ~cpol;
        mosi = bit_at(i, nbits);
        tick(HALF);
        got = {got[6:0], miso};
        sck = cpol;
        tick(HALF);
      end
      if (i % 8 == 7) begin
        if (miso_exp.size() == 0) check("miso_unexpected", got, 8'hxx);
        else check("miso_byte", got, miso_exp.pop_front());
      end
    end
    tick(1);
    cs_n = 1'b1;
    tick(6);
  endtask

  // Receive scoreboard: every rx_valid pulse must match a queued byte.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      if (rx_exp.size() == 0) check("rx_unexpected", rx_data, 8'hxx);
      else check("rx_byte", rx_data, rx_exp.pop_front());
    end
  end

  initial begin
    #200us;
    n_errors++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int rx_before;
    rst = 1'b1; mode = 2'b00; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
    status_clr = 1'b0;
`endif
    tick(3);
    rst = 1'b0;
    tick(2);
    check("rst_miso", miso, 1'b1);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
`ifdef SPI_SLAVE_STATUS_EN
    check("rst_underrun", tx_underrun, 1'b0);
    check("rst_abort", frame_abort, 1'b0);
`endif

    // Mode 0 single byte: A5 out, 3C in.
    tx_push(8'hA5);
    check("t1_ready_low", tx_ready, 1'b0);
    miso_exp.push_back(8'hA5);
    mosi_buf[0] = 8'h3C;
    spi_xfer(2'b00, 8, -1);
    check("t1_ready_back", tx_ready, 1'b1);
    check("t1_rx_cnt", rx_cnt, 1);
    check("t1_rx_data", rx_data, 8'h3C);
    check("t1_idle_miso", miso, 1'b1);
    check("t1_idle_oe", miso_oe, 1'b0);

    // Modes 1..3: 81 out, 7E in.
    for (int m = 1; m < 4; m++) begin
      tx_push(8'h81);
      miso_exp.push_back(8'h81);
      mosi_buf[0] = 8'h7E;
      spi_xfer(m[1:0], 8, -1);
      check("t2_rx_data", rx_data, 8'h7E);
    end

    // Three-byte frame (mode 1) with only two loads: third byte underruns.
    status_clear();
    rx_before = rx_cnt;
    tx_push(8'h11);
    miso_exp.push_back(8'h11);
    miso_exp.push_back(8'h22);
    miso_exp.push_back(8'hFF);
    mosi_buf[0] = 8'hC1; mosi_buf[1] = 8'h5E; mosi_buf[2] = 8'h09;
    fork
      spi_xfer(2'b01, 24, -1);
      tx_push(8'h22);
    join
    check("t3_rx_cnt", rx_cnt - rx_before, 3);
`ifdef SPI_SLAVE_STATUS_EN
    check("t3_underrun", tx_underrun, 1'b1);
    check("t3_no_abort", frame_abort, 1'b0);
`endif

    // Abort after 5 bits, then a clean frame starting from bit 7.
    status_clear();
    rx_before = rx_cnt;
    tx_push(8'h96);
    mosi_buf[0] = 8'hF0;
    spi_xfer(2'b00, 5, -1);
    check("t4_no_rx", rx_cnt - rx_before, 0);
`ifdef SPI_SLAVE_STATUS_EN
    check("t4_abort", frame_abort, 1'b1);
`endif
    tx_push(8'h4B);
    miso_exp.push_back(8'h4B);
    mosi_buf[0] = 8'h2D;
    spi_xfer(2'b00, 8, -1);
    check("t4_rx_data", rx_data, 8'h2D);

    // Load in the same cycle as the byte-boundary reload with holding empty.
    tx_push(8'h5A);
    miso_exp.push_back(8'h5A);
    miso_exp.push_back(8'hFF);
    miso_exp.push_back(8'hC3);
    mosi_buf[0] = 8'h01; mosi_buf[1] = 8'h02; mosi_buf[2] = 8'h03;
    spi_xfer(2'b00, 24, 7);

    // Reset in the middle of a byte.
    rx_before = rx_cnt;
    tx_push(8'h77);
    mode = 2'b00; sck = 1'b0; mosi = 1'b1;
    tick(4);
    cs_n = 1'b0;
    tick(6);
    tx_push(8'h88);
    check("t6_ready_low", tx_ready, 1'b0);
    for (int b = 0; b < 3; b++) begin
      sck = 1'b1; tick(HALF);
      sck = 1'b0; tick(HALF);
    end
    check("t6_oe_before", miso_oe, 1'b1);
    rst = 1'b1;
    tick(1);
    check("t6_miso", miso, 1'b1);
    check("t6_miso_oe", miso_oe, 1'b0);
    check("t6_tx_ready", tx_ready, 1'b1);
    check("t6_rx_data", rx_data, 8'h00);
    check("t6_rx_valid", rx_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
`ifdef SPI_SLAVE_STATUS_EN
    check("t6_underrun", tx_underrun, 1'b0);
    check("t6_abort", frame_abort, 1'b0);
`endif
    tick(2);
    cs_n = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(8);
    check("t6_no_rx", rx_cnt - rx_before, 0);
    check("t6_busy_after", busy, 1'b0);
    // Holding register was emptied by reset, so the next byte underruns.
    miso_exp.push_back(8'hFF);
    mosi_buf[0] = 8'hE7;
    spi_xfer(2'b00, 8, -1);
    check("t6_rx_data_after", rx_data, 8'hE7);

    tick(4);
    check("rx_pending", rx_exp.size(), 0);
    check("miso_pending", miso_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
